// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ir_pkg
//  Description : Shared constants and helpers for the IR input-conditioning
//                stage: default channel count, channel index names and the
//                debounce counter width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package ir_pkg;

  // Default number of IR obstacle sensors on the robot.
  localparam int IR_N_CH = 4;

  // Channel index names, bit0 of the sensor bus is IR1.
  localparam int IR1 = 0;
  localparam int IR2 = 1;
  localparam int IR3 = 2;
  localparam int IR4 = 3;

  // Width of a counter that must hold values 0..stable_cnt.
  function automatic int cnt_width(input int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : ir_debounce_if
//  Description : Sensor-side / steering-side signal bundle of the IR debounce
//                stage.
//  Revision    : 1.0 - initial release
//
//  Signals:
//    ir_raw      [N_CH] raw asynchronous sensor lines (bit0 = IR1)
//    ir_clean    [N_CH] debounced levels
//    ir_changed  [1]    one-cycle pulse after any ir_clean bit updates
//    sample_tick [1]    one-cycle pulse at the sampling rate
//    ir_fault    [N_CH] per-channel bounce fault flags
//
//  Modports:
//    master : drives ir_raw, observes the conditioned outputs
//    slave  : the debounce block itself
// ============================================================================
interface ir_debounce_if
  import ir_pkg::*;
#(
  parameter int N_CH = IR_N_CH
);

  logic [N_CH-1:0] ir_raw;
  logic [N_CH-1:0] ir_clean;
  logic            ir_changed;
  logic            sample_tick;
  logic [N_CH-1:0] ir_fault;

  modport master (
    output ir_raw,
    input  ir_clean,
    input  ir_changed,
    input  sample_tick,
    input  ir_fault
  );

  modport slave (
    input  ir_raw,
    output ir_clean,
    output ir_changed,
    output sample_tick,
    output ir_fault
  );

endinterface
`default_nettype wire

// File: rtl/ir_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : ir_debounce_ch
//  Description : One IR channel: 2-flop synchroniser, stability counter,
//                clean level register and (when IR_STUCK_DETECT_EN is
//                defined) an aborted-transition counter with sticky fault.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk    in  system clock
//    rst_n  in  synchronous active-low reset
//    tick   in  sampling strobe, evaluation happens only when high
//    raw    in  asynchronous sensor line
//    clean  out debounced level
//    fault  out sticky bounce fault (constant 0 without IR_STUCK_DETECT_EN)
//
//  Optional feature macro: IR_STUCK_DETECT_EN
// ============================================================================
module ir_debounce_ch
  import ir_pkg::*;
#(
  parameter int   STABLE_CNT  = 8,
  parameter logic CLEAN_RST   = 1'b1
`ifdef IR_STUCK_DETECT_EN
  ,
  parameter int   FAULT_LIMIT = 16
`endif
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  tick,
  input  wire  raw,
  output logic clean,
  output logic fault
);

  localparam int             CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          differs;
  logic          accept;

  assign differs = sync_b ^ clean;
  // The new level is taken on the STABLE_CNT-th consecutive differing sample.
  assign accept  = tick & differs & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= CLEAN_RST;
      sync_b <= CLEAN_RST;
      cnt    <= '0;
      clean  <= CLEAN_RST;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (accept) begin
        clean <= sync_b;
        cnt   <= '0;
      end else if (tick) begin
        // A sample equal to the current level aborts any pending transition.
        cnt <= differs ? cnt + 1'b1 : '0;
      end
    end
  end

`ifdef IR_STUCK_DETECT_EN
  localparam int            AW      = $clog2(FAULT_LIMIT + 1);
  localparam logic [AW-1:0] ABT_MAX = AW'(FAULT_LIMIT);

  logic          abort;
  logic [AW-1:0] abt;
  logic          fault_q;

  assign abort = tick & ~differs & (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abt     <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      // A successful transition forgives earlier bounces; the fault stays.
      abt <= '0;
    end else if (abort && (abt != ABT_MAX)) begin
      abt <= abt + 1'b1;
      if (abt == ABT_MAX - 1'b1) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/ir_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : ir_debounce
//  Description : Input-conditioning stage for the IR obstacle sensors.
//                Synchronises each raw line, samples it on a prescaled tick
//                and accepts a new level only after STABLE_CNT consecutive
//                differing samples. Produces a one-cycle change pulse.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk    in  system clock
//    rst_n  in  synchronous active-low reset
//    bus    ir_debounce_if.slave : ir_raw in, ir_clean / ir_changed /
//           sample_tick / ir_fault out
//
//  Optional feature macro: IR_STUCK_DETECT_EN (per-channel bounce fault)
// ============================================================================
module ir_debounce
  import ir_pkg::*;
#(
  parameter int              N_CH        = IR_N_CH,
  parameter int              CLK_HZ      = 50000000,
  parameter int              SAMPLE_HZ   = 1000,
  parameter int              STABLE_CNT  = 8,
  parameter logic [N_CH-1:0] CLEAN_RST   = {N_CH{1'b1}},
  parameter int              FAULT_LIMIT = 16
) (
  input  wire               clk,
  input  wire               rst_n,
  ir_debounce_if.slave      bus
);

  localparam int            DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  if ((DIV < 2) || (STABLE_CNT < 1) || (STABLE_CNT > 255) || (FAULT_LIMIT < 1))
  begin : g_param_check
    $error("ir_debounce: illegal parameter combination");
  end

  logic [PW-1:0]   pcnt;
  logic            tick;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] clean_prev;
  logic [N_CH-1:0] fault;
  logic            changed;

  // Prescaler: the tick is registered, so it is high the cycle after the
  // count sits at DIV-1; the first tick lands DIV cycles after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PCNT_LAST);
      pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ir_debounce_ch #(
      .STABLE_CNT  (STABLE_CNT),
      .CLEAN_RST   (CLEAN_RST[i])
`ifdef IR_STUCK_DETECT_EN
      ,
      .FAULT_LIMIT (FAULT_LIMIT)
`endif
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (bus.ir_raw[i]),
      .clean (clean[i]),
      .fault (fault[i])
    );
  end

  // Comparing against last cycle's levels turns any number of simultaneous
  // channel updates into a single pulse one cycle after ir_clean moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean_prev <= CLEAN_RST;
      changed    <= 1'b0;
    end else begin
      clean_prev <= clean;
      changed    <= |(clean ^ clean_prev);
    end
  end

  assign bus.ir_clean    = clean;
  assign bus.ir_changed  = changed;
  assign bus.sample_tick = tick;
  assign bus.ir_fault    = fault;

endmodule
`default_nettype wire

// File: tb/tb_ir_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ir_debounce
//  Description : Directed self-checking bench for ir_debounce with
//                CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), STABLE_CNT=4,
//                FAULT_LIMIT=3. Expected values are hand-computed: a raw
//                change applied on a tick cycle becomes visible on ir_clean
//                41 cycles later and ir_changed pulses at 42.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_debounce;
  import ir_pkg::*;

  localparam int DIV = 10;
`ifdef IR_STUCK_DETECT_EN
  localparam logic [3:0] FAULT_EXP = 4'b1000;
`else
  localparam logic [3:0] FAULT_EXP = 4'b0000;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_debounce_if #(.N_CH(4)) bus ();

  ir_debounce #(
    .N_CH        (4),
    .CLK_HZ      (1000),
    .SAMPLE_HZ   (100),
    .STABLE_CNT  (4),
    .CLEAN_RST   (4'b1111),
    .FAULT_LIMIT (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles sampling on falling edges. Reports the first cycle
  // ir_clean equals target, the number and first position of ir_changed
  // pulses, the number of ir_clean transitions and the OR of ir_fault.
  task automatic run(input int n, input logic [3:0] target,
                     output int hit, output int n_chg, output int chg_at,
                     output int n_edges, output logic [3:0] fault_or);
    logic [3:0] prev;
    hit = -1; n_chg = 0; chg_at = -1; n_edges = 0; fault_or = 4'b0000;
    prev = bus.ir_clean;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (bus.ir_clean === target && hit < 0) hit = j;
      if (bus.ir_changed === 1'b1) begin
        n_chg++;
        if (chg_at < 0) chg_at = j;
      end
      if (bus.ir_clean !== prev) n_edges++;
      prev     = bus.ir_clean;
      fault_or = fault_or | bus.ir_fault;
    end
  endtask

  // Move to the next falling edge where sample_tick is high (bounded).
  task automatic align();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 2 * DIV && !found; k++) begin
      @(negedge clk);
      if (bus.sample_tick === 1'b1) found = 1'b1;
    end
    check("tick_align", {31'd0, found}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit, n_chg, chg_at, n_edges, tot_chg, tot_edges;
    logic [3:0] f_or, f_acc;

    // ---------------- 1. reset ----------------
    bus.ir_raw = 4'b0000;
    rst_n      = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_clean",   {28'd0, bus.ir_clean}, 32'hF);
    check("rst_changed", {31'd0, bus.ir_changed}, 32'd0);
    check("rst_tick",    {31'd0, bus.sample_tick}, 32'd0);
    check("rst_fault",   {28'd0, bus.ir_fault}, 32'd0);
    bus.ir_raw = 4'b1111;
    rst_n      = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("first_tick_c%0d", k), {31'd0, bus.sample_tick}, {31'd0, k == 10});
    end

    // ---------------- 2. clean step on IR1 ----------------
    bus.ir_raw[IR1] = 1'b0;
    run(45, 4'b1110, hit, n_chg, chg_at, n_edges, f_or);
    check("step_hit",     hit, 41);
    check("step_nchg",    n_chg, 1);
    check("step_chg_at",  chg_at, 42);
    check("step_edges",   n_edges, 1);
    check("step_final",   {28'd0, bus.ir_clean}, 32'hE);

    // ---------------- 3. glitch rejection on IR3 ----------------
    align();
    bus.ir_raw[IR3] = 1'b0;
    run(30, 4'b1010, hit, n_chg, chg_at, n_edges, f_or);
    check("glitch_low_hit",  hit, -1);
    check("glitch_phase",    {31'd0, bus.sample_tick}, 32'd1);
    bus.ir_raw[IR3] = 1'b1;
    run(20, 4'b1010, hit, n_chg, chg_at, n_edges, f_or);
    check("glitch_edges",    n_edges, 0);
    check("glitch_nchg",     n_chg, 0);
    check("glitch_clean",    {28'd0, bus.ir_clean}, 32'hE);
    // A fresh step now needs all four ticks again, so the count was cleared.
    bus.ir_raw[IR3] = 1'b0;
    run(45, 4'b1010, hit, n_chg, chg_at, n_edges, f_or);
    check("glitch_restart_hit", hit, 41);
    check("glitch_restart_chg", n_chg, 1);

    // Two channels rising together.
    align();
    bus.ir_raw = 4'b1111;
    run(45, 4'b1111, hit, n_chg, chg_at, n_edges, f_or);
    check("rise2_hit",   hit, 41);
    check("rise2_edges", n_edges, 1);
    check("rise2_nchg",  n_chg, 1);

    // ---------------- 4. simultaneous update IR2/IR4 ----------------
    align();
    bus.ir_raw = 4'b0101;
    run(45, 4'b0101, hit, n_chg, chg_at, n_edges, f_or);
    check("simul_hit",    hit, 41);
    check("simul_edges",  n_edges, 1);
    check("simul_nchg",   n_chg, 1);
    check("simul_chg_at", chg_at, 42);
    align();
    bus.ir_raw = 4'b1111;
    run(45, 4'b1111, hit, n_chg, chg_at, n_edges, f_or);
    check("simul_back_hit", hit, 41);

    // ---------------- 5. reset mid-count on IR2 ----------------
    align();
    bus.ir_raw[IR2] = 1'b0;
    run(22, 4'b1101, hit, n_chg, chg_at, n_edges, f_or);
    check("midrst_pre_hit", hit, -1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_clean",   {28'd0, bus.ir_clean}, 32'hF);
    check("midrst_changed", {31'd0, bus.ir_changed}, 32'd0);
    check("midrst_tick",    {31'd0, bus.sample_tick}, 32'd0);
    rst_n = 1'b1;
    run(45, 4'b1101, hit, n_chg, chg_at, n_edges, f_or);
    check("midrst_hit",  hit, 41);
    check("midrst_nchg", n_chg, 1);

    // ---------------- 6. bounce fault on IR4 ----------------
    align();
    bus.ir_raw = 4'b1111;
    run(45, 4'b1111, hit, n_chg, chg_at, n_edges, f_or);
    check("bounce_prep_hit", hit, 41);
    align();
    tot_chg = 0; tot_edges = 0; f_acc = 4'b0000;
    for (int r = 0; r < 3; r++) begin
      bus.ir_raw[IR4] = 1'b0;
      run(20, 4'b0111, hit, n_chg, chg_at, n_edges, f_or);
      tot_chg += n_chg; tot_edges += n_edges; f_acc |= f_or;
      bus.ir_raw[IR4] = 1'b1;
      run(10, 4'b0111, hit, n_chg, chg_at, n_edges, f_or);
      tot_chg += n_chg; tot_edges += n_edges; f_acc |= f_or;
    end
    // Third abort is evaluated on the edge right after this point.
    check("bounce_fault_early", {28'd0, f_acc}, 32'd0);
    run(25, 4'b0111, hit, n_chg, chg_at, n_edges, f_or);
    tot_chg += n_chg; tot_edges += n_edges;
    check("bounce_fault",  {28'd0, bus.ir_fault}, {28'd0, FAULT_EXP});
    check("bounce_edges",  tot_edges, 0);
    check("bounce_nchg",   tot_chg, 0);
    check("bounce_clean",  {28'd0, bus.ir_clean}, 32'hF);
    run(30, 4'b0111, hit, n_chg, chg_at, n_edges, f_or);
    check("bounce_fault_held", {28'd0, bus.ir_fault}, {28'd0, FAULT_EXP});
    rst_n = 1'b0;
    @(negedge clk);
    check("bounce_fault_rst", {28'd0, bus.ir_fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_debounce.md
Name: ir_debounce

Overview:
- Input-conditioning stage between the four raw IR obstacle sensors and the motor-decision logic.
- Synchronises each asynchronous IR line and samples it on a slow prescaled tick.
- Accepts a new level only after it has held for STABLE_CNT consecutive samples.
- Drives clean, glitch-free IR levels plus a one-cycle change pulse to the downstream steering block.

Parameters:
- N_CH, 4, number of IR channels.
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 1000, sampling tick rate; DIV = CLK_HZ/SAMPLE_HZ, must be >= 2.
- STABLE_CNT, 8, consecutive differing samples required to accept a new level; range 1..255.
- CLEAN_RST, {N_CH{1'b1}}, reset value of ir_clean (all channels "no obstacle").
- FAULT_LIMIT, 16, aborted transitions before a fault is flagged (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ir_raw  in  N_CH  raw asynchronous sensor lines, bit0 = IR1.
- ir_clean  out  N_CH  debounced levels.
- ir_changed  out  1  one-cycle pulse, high when any ir_clean bit updates.
- sample_tick  out  1  one-cycle pulse at SAMPLE_HZ, for downstream timing.
- ir_fault  out  N_CH  per-channel bounce fault flag; tied 0 without the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: ir_clean = CLEAN_RST; ir_changed = 0; sample_tick = 0; ir_fault = 0; prescaler = 0; all counters = 0; synchroniser flops = CLEAN_RST.
- Synchroniser: 2-flop synchroniser per bit. Its output is sync[i].
- Prescaler: counts 0..DIV-1 and wraps to 0. sample_tick is registered and is high for exactly the one cycle after the count equals DIV-1. First tick arrives DIV cycles after reset release.
- Per-channel evaluation happens only on cycles with sample_tick = 1.
  - sync[i] == ir_clean[i]: cnt[i] <= 0, and the pending transition is aborted.
  - sync[i] != ir_clean[i] and cnt[i] == STABLE_CNT-1: ir_clean[i] <= sync[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
- Channels are independent. Several channels may update on the same tick; this produces a single ir_changed pulse.
- ir_changed is registered and is high the cycle after any ir_clean bit changes.
- Latency: a clean raw step reaches ir_clean after 2 sync cycles plus STABLE_CNT ticks, i.e. worst case 2 + STABLE_CNT*DIV cycles.
- Boundary cases:
  - STABLE_CNT = 1: accept on the first differing sample.
  - cnt width = clog2(STABLE_CNT+1); cnt never exceeds STABLE_CNT-1.
  - Reset mid-count: the count is discarded and ir_clean returns to CLEAN_RST.
  - A raw pulse shorter than one tick period may be missed entirely; this is intended.

Optional Feature:
- Macro: IR_STUCK_DETECT_EN.
- With the macro defined:
  - Per-channel abort counter abt[i], incremented when a pending transition is aborted (cnt[i] != 0 and sync[i] == ir_clean[i] on a tick).
  - abt[i] clears when ir_clean[i] updates.
  - When abt[i] reaches FAULT_LIMIT, ir_fault[i] is set and stays set. It is cleared only by reset.
  - abt[i] saturates at FAULT_LIMIT.
- Without the macro: no abort counters are generated and ir_fault is constant 0.

Decomposition:
- Package ir_pkg holds:
  - N_CH default;
  - the channel index constants IR1..IR4 = 0..3;
  - a function computing counter width from STABLE_CNT.
- Sub-module ir_debounce_ch: one channel (synchroniser, cnt, clean bit, optional abort counter). It is instantiated N_CH times in a generate loop.
- The prescaler and the ir_changed OR-reduction live in the top module.

Test Plan:
All scenarios use CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), STABLE_CNT=4, FAULT_LIMIT=3.
1. Reset: hold rst_n=0 for 5 cycles with ir_raw=4'b0000 -> ir_clean=4'b1111, ir_changed=0, sample_tick=0. After release, first sample_tick occurs at cycle 10.
2. Clean step: ir_raw[0] 1->0 and held -> ir_clean[0]=0 after the 4th subsequent tick (within 42 cycles). ir_changed pulses exactly once; other bits stay unchanged.
3. Glitch rejection: ir_raw[2] low for 3 ticks, then high -> ir_clean stays 4'b1111, no ir_changed pulse, cnt[2] back to 0.
4. Simultaneous update: ir_raw 4'b1111->4'b0101 on the same cycle -> bits 1 and 3 update on the same cycle, with a single ir_changed pulse.
5. Reset mid-count: ir_raw[1]=0 held for 2 ticks, then rst_n=0 for 1 cycle -> ir_clean=4'b1111. After release, 4 further ticks are needed before ir_clean[1]=0.
6. With IR_STUCK_DETECT_EN: toggle ir_raw[3] low for 2 ticks / high for 1 tick, repeated 3 times -> ir_fault[3]=1 and held until reset; ir_clean[3] stays 1. Without the macro: ir_fault remains 0.
